onchip_mem_arbiter: RTL and testbench



---
 rtl/onchip_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter for the single-port on-chip RAM.
// Define ONCHIP_MEM_ARB_FIXED_PRIO_EN for fixed master-0 priority.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [7:0] CAP = 8'(MAX_HOLD);

  logic       last_grant_q, last_grant_d;
  logic       owner_locked_q, owner_locked_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;

  logic req0, req1;
  logic own_req, oth_req;
  logic under_cap;
  logic gnt_vld, gnt_id;
  logic gnt_wr, gnt_lock;

  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    own_req   = last_grant_q ? req1 : req0;
    oth_req   = last_grant_q ? req0 : req1;
    under_cap = hold_cnt_q < CAP;
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    if (reset_n) begin
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
      if (req1 && (!req0 || (owner_locked_q && last_grant_q
                             && under_cap))) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end else if (req0) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
`else
      if (owner_locked_q && own_req && (!oth_req || under_cap)) begin
        gnt_vld = 1'b1;
        gnt_id  = last_grant_q;
      end else if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt_id  = !last_grant_q;
      end else if (req0) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
`endif
    end
  end

  // Master 0 ignores its lock input under fixed priority.
  always_comb begin
    gnt_wr = gnt_id ? m1_write : m0_write;
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
    gnt_lock = gnt_id & m1_lock;
`else
    gnt_lock = gnt_id ? m1_lock : m0_lock;
`endif
  end

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (gnt_vld && gnt_id) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
    mem_chipselect = gnt_vld;
    mem_write      = gnt_vld & gnt_wr;
    mem_clken      = 1'b1;
  end

  always_comb begin
    m0_waitrequest   = !(gnt_vld && !gnt_id);
    m1_waitrequest   = !(gnt_vld && gnt_id);
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = reset_n & rd_pend_q & !rd_id_q;
    m1_readdatavalid = reset_n & rd_pend_q & rd_id_q;
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    owner_locked_d = owner_locked_q;
    hold_cnt_d     = hold_cnt_q;
    rd_pend_d      = 1'b0;
    rd_id_d        = rd_id_q;
    if (gnt_vld) begin
      last_grant_d   = gnt_id;
      owner_locked_d = gnt_lock;
      if (owner_locked_q && last_grant_q == gnt_id) begin
        hold_cnt_d = (hold_cnt_q == 8'hFF) ? 8'hFF
                                           : hold_cnt_q + 8'd1;
      end else begin
        hold_cnt_d = 8'd1;
      end
      rd_pend_d = !gnt_wr;
      rd_id_d   = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q   <= 1'b1;
      owner_locked_q <= 1'b0;
      hold_cnt_q     <= 8'd0;
      rd_pend_q      <= 1'b0;
      rd_id_q        <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      owner_locked_q <= owner_locked_d;
      hold_cnt_q     <= hold_cnt_d;
      rd_pend_q      <= rd_pend_d;
      rd_id_q        <= rd_id_d;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural RAM.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock;
  logic        m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(
    .ADDR_W(12), .DATA_W(32), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  logic [31:0] ram [0:4095];

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle;
    m0_read = 0; m0_write = 0; m0_lock = 0;
    m1_read = 0; m1_write = 0; m1_lock = 0;
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic m0_wr(input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    m0_write = 1; m0_read = 0;
    m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic m0_rd(input logic [11:0] a);
    m0_write = 0; m0_read = 1;
    m0_address = a; m0_byteenable = 4'hF;
  endtask

  task automatic m1_rd(input logic [11:0] a);
    m1_write = 0; m1_read = 1;
    m1_address = a; m1_byteenable = 4'hF;
  endtask

  initial begin
    idle();
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    reset_n = 0;
    m0_rd(12'h010); m1_rd(12'h020);
    next();
    @(negedge clk);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_we", mem_write, 0);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    chk("clken", mem_clken, 1);
    next();
    reset_n = 1;
    idle();

    // write then immediate read of the same word
    m0_wr(12'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("t1_wr_wait", m0_waitrequest, 0);
    chk("t1_wr_cs", mem_chipselect, 1);
    chk("t1_wr_we", mem_write, 1);
    chk("t1_wr_addr", 32'(mem_address), 32'h010);
    next();
    m0_rd(12'h010);
    @(negedge clk);
    chk("t1_rd_wait", m0_waitrequest, 0);
    chk("t1_rd_we", mem_write, 0);
    chk("t1_rdv_early", m0_readdatavalid, 0);
    next();
    idle();
    @(negedge clk);
    chk("t1_rdv", m0_readdatavalid, 1);
    chk("t1_m1_rdv", m1_readdatavalid, 0);
    chk("t1_data", m0_readdata, 32'hDEADBEEF);
    chk("t1_idle_cs", mem_chipselect, 0);
    next();

    // byte-enable merge
    m0_wr(12'h020, 32'h11223344, 4'hF);
    next();
    m0_wr(12'h020, 32'hAABBCCDD, 4'h2);
    next();
    m0_rd(12'h020);
    next();
    idle();
    @(negedge clk);
    chk("t2_rdv", m0_readdatavalid, 1);
    chk("t2_data", m0_readdata, 32'h1122CC44);
    next();

`ifndef ONCHIP_MEM_ARB_FIXED_PRIO_EN
    reset_n = 0;
    next();
    reset_n = 1;
    // round robin, no lock
    begin
      logic prev;
      prev = 0;
      for (int i = 0; i < 6; i++) begin
        m0_rd(12'h010); m1_rd(12'h020);
        @(negedge clk);
        chk($sformatf("rr%0d_m0_wait", i), m0_waitrequest,
            32'((i % 2) != 0));
        chk($sformatf("rr%0d_m1_wait", i), m1_waitrequest,
            32'((i % 2) == 0));
        if (i > 0) begin
          chk($sformatf("rr%0d_m0_rdv", i), m0_readdatavalid,
              32'(prev == 0));
          chk($sformatf("rr%0d_m1_rdv", i), m1_readdatavalid,
              32'(prev == 1));
          chk($sformatf("rr%0d_data", i), m0_readdata,
              prev ? 32'h1122CC44 : 32'hDEADBEEF);
        end
        prev = (i % 2 == 1);
        next();
      end
      idle();
      @(negedge clk);
      chk("rr_tail_m1_rdv", m1_readdatavalid, 1);
      chk("rr_tail_m0_rdv", m0_readdatavalid, 0);
      next();
    end

    // locked burst capped at 4 grants
    m0_rd(12'h010);
    next();
    idle();
    begin
      logic [6:0] exp_g;
      exp_g = 7'b1101111;
      for (int i = 0; i < 7; i++) begin
        m0_rd(12'h010); m1_rd(12'h020); m1_lock = 1;
        @(negedge clk);
        chk($sformatf("lk%0d_m1_wait", i), m1_waitrequest,
            32'(!exp_g[i]));
        chk($sformatf("lk%0d_m0_wait", i), m0_waitrequest,
            32'(exp_g[i]));
        next();
      end
    end
    idle();
    next();
`endif

    // reset right after an accepted m1 read
    m1_rd(12'h020);
    @(negedge clk);
    chk("t5_m1_acc", m1_waitrequest, 0);
    next();
    reset_n = 0;
    m0_rd(12'h010); m1_rd(12'h020);
    @(negedge clk);
    chk("t5_m1_rdv", m1_readdatavalid, 0);
    chk("t5_m0_rdv", m0_readdatavalid, 0);
    chk("t5_rst_cs", mem_chipselect, 0);
    chk("t5_rst_wait", m1_waitrequest, 1);
    next();
    reset_n = 1;
    @(negedge clk);
    chk("t5_tie_m0", m0_waitrequest, 0);
    chk("t5_tie_m1", m1_waitrequest, 1);
    chk("t5_no_rdv", m1_readdatavalid, 0);
    next();

`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 10; i++) begin
      m0_rd(12'h010); m1_rd(12'h020);
      @(negedge clk);
      chk($sformatf("fp%0d_m0_wait", i), m0_waitrequest, 0);
      chk($sformatf("fp%0d_m1_wait", i), m1_waitrequest, 1);
      next();
    end
`else
    @(negedge clk);
    chk("t5_m1_next", m1_waitrequest, 0);
    chk("t5_m0_rdv_after", m0_readdatavalid, 1);
    chk("t5_m0_data", m0_readdata, 32'hDEADBEEF);
    next();
`endif
    idle();
    next();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
